udp_perf_rx_checker: RTL and testbench
======================================

// Module: udp_perf_rx_checker
// PURPOSE
//  Receive-side counterpart of the UDP/CMAC perf traffic generator.
//  - Sinks the 512-bit AXI-Stream coming out of the UDP RX path on the XDMA clock.
//  - Checks each packet against the generator pattern (length, tkeep, payload, sequence).
//  - Keeps packet, error, beat and throughput-window counters for ILA/register readout.
// PARAMETERS
//  DATA_WIDTH  512  tdata width; a multiple of 32
//  KEEP_WIDTH  64   tkeep width, DATA_WIDTH/8
//  USER_WIDTH  1    tuser width; bit 0 = upstream error flag
//  CNT_WIDTH   32   width of every statistics counter
// PORTS
//  xdma_clk            in   1           single clock for the whole block
//  xdma_reset          in   1           reset: asynchronous, active-high
//  rx_axis_tvalid      in   1           AXIS beat valid
//  rx_axis_tready      out  1           AXIS ready
//  rx_axis_tdata       in   DATA_WIDTH  payload
//  rx_axis_tkeep       in   KEEP_WIDTH  byte enables, LSB = byte 0
//  rx_axis_tlast       in   1           last beat of packet
//  rx_axis_tuser       in   USER_WIDTH  bit0 = 1 marks a bad frame
//  cfg_enable          in   1           checking enable, level
//  cfg_pkt_size        in   16          expected packet length in bytes, 1..65535
//  cfg_clear           in   1           one-cycle pulse: zero all stats
//  is_recv_first_pkt   out  1           set once the first packet head is checked
//  recv_pkt_num        out  CNT_WIDTH   packets completed
//  err_pkt_num         out  CNT_WIDTH   packets with at least one error
//  total_beat_count    out  CNT_WIDTH   beats accepted while checking; wraps
//  perf_beat_count     out  CNT_WIDTH   beats accepted inside the perf window
//  perf_cycle_count    out  CNT_WIDTH   cycles elapsed in the perf window
//  perf_cycle_full     out  1           perf window saturated
// BEHAVIOUR
//  Reset values: every output is 0 except rx_axis_tready. tready is 1 immediately after reset.
//  Handshake
//  - rx_axis_tready is constant 1; the block never backpressures CMAC.
//  - A beat is accepted when tvalid=1.
//  Packet boundaries
//  - A sticky in_pkt flag tracks packet boundaries continuously: set on an accepted non-last beat, cleared on tlast.
//  FSM, evaluated on accepted beats
//  - IDLE: cfg_enable=0; beats are discarded.
//  - enable rises with in_pkt=1 -> DROP: discard beats until tlast, then go to HEAD.
//  - enable rises with in_pkt=0 -> HEAD.
//  - HEAD: beat index b=0; capture seq = tdata[31:0]; go to BODY, or stay in HEAD if tlast.
//  - BODY: b increments per beat; tlast returns to HEAD.
//  - Enable falling: the current packet is finished and counted; the FSM then goes to IDLE at tlast.
//  Expected pattern
//  - Every 32-bit lane of beat b equals seq+b, mod 2^32.
//  - Beat count N = ceil(cfg_pkt_size/64).
//  - tkeep is all-ones on beats 0..N-2.
//  - Last beat: the low (cfg_pkt_size mod 64) bits of tkeep are set; all 64 bits if the remainder is 0.
//  - cfg_pkt_size is sampled at HEAD and held for the whole packet.
//  Packet error (sticky per packet) if any of:
//  - a lane with all 4 keep bits set mismatches;
//  - tkeep differs from expected;
//  - tlast arrives at b != N-1;
//  - b reaches N without tlast;
//  - tuser[0]=1 on any beat;
//  - seq != exp_seq, but only once is_recv_first_pkt=1.
//  - In the overlong case, remaining beats are still consumed until tlast; b saturates.
//  Sequence tracking
//  - exp_seq <= seq+1 at every HEAD. The checker resyncs after loss, so a lost packet costs exactly one error.
//  Counters
//  - recv_pkt_num increments, and err_pkt_num also increments if the packet errored, 1 cycle after the tlast beat.
//  - The last-beat checks are included in that update.
//  - total_beat_count increments 1 cycle after each beat accepted outside IDLE/DROP.
//  Perf window
//  - Opens on the first HEAD beat after reset/clear; is_recv_first_pkt is set in the same update.
//  - perf_cycle_count increments every cycle while open.
//  - perf_beat_count counts the same beats as total_beat_count.
//  - At all-ones, perf_cycle_full=1 and both perf counters freeze.
//  - perf counters keep running when enable drops.
//  cfg_clear
//  - Zeroes all counters, is_recv_first_pkt and perf_cycle_full.
//  - Has priority over same-cycle increments.
//  - Does not change FSM state.
//  - The next HEAD reopens the window and skips the seq check.
//  Async reset mid-packet: everything returns to IDLE, in_pkt=0, all stats 0.
//  - If enable=1 after reset release, the first tlast-terminated remainder passes via HEAD and may count one error.
//  - The bench must start traffic cleanly.
// TESTING
//  T1: pkt_size=256, 4 good pkts seq 0..3 (4 beats each) -> recv=4, err=0, total_beat=16, first_pkt=1.
//  T2: pkt_size=100, 2 beats, last tkeep=0xF_FFFF_FFFF, lane corrupted in beat1 of pkt 2 of 3 -> recv=3, err=1.
//  T3: seq 10,11,13,14 at pkt_size=64 -> err=1 (pkt seq 13 only), recv=4.
//  T4: tlast early (beat 1 of 4) then pkt with 6 beats, tuser=1 on 3rd pkt -> err=3, recv=3, total_beat=2+6+4=12.
//  T5: enable raised mid-packet (2 beats left) -> both dropped, next pkt checked, total_beat counts only it.
//  T6: CNT_WIDTH=8, continuous traffic -> perf_cycle_full=1 at 255 cycles, perf counters frozen; cfg_clear -> all 0, next pkt reopens window.

Source files
------------

// File: rtl/udp_perf_rx_checker.sv
// Receive-side checker for the UDP/CMAC perf generator: verifies length, tkeep,
// lane pattern and sequence of each packet and keeps throughput statistics.
module udp_perf_rx_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  xdma_clk,
  input  logic                  xdma_reset,
  input  logic                  rx_axis_tvalid,
  output logic                  rx_axis_tready,
  input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
  input  logic                  rx_axis_tlast,
  input  logic [USER_WIDTH-1:0] rx_axis_tuser,
  input  logic                  cfg_enable,
  input  logic [15:0]           cfg_pkt_size,
  input  logic                  cfg_clear,
  output logic                  is_recv_first_pkt,
  output logic [CNT_WIDTH-1:0]  recv_pkt_num,
  output logic [CNT_WIDTH-1:0]  err_pkt_num,
  output logic [CNT_WIDTH-1:0]  total_beat_count,
  output logic [CNT_WIDTH-1:0]  perf_beat_count,
  output logic [CNT_WIDTH-1:0]  perf_cycle_count,
  output logic                  perf_cycle_full,
  output logic [1:0]            fsm_state
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int KB    = $clog2(KEEP_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CYC_LAST = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DROP = 2'd1,
    S_HEAD = 2'd2,
    S_BODY = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   in_pkt_q, in_pkt_d;

  logic [31:0]           seq_q, exp_seq_q;
  logic [15:0]           size_q, b_q;
  logic                  err_q, perf_open_q;

  logic                  beat, check_beat, is_head;
  logic [15:0]           cur_size, cur_b;
  logic [31:0]           cur_seq, lane_exp;
  logic [16:0]           n_beats, last_idx, b_ext;
  logic [KB-1:0]         rem;
  logic [KEEP_WIDTH-1:0] exp_keep;
  logic                  lane_err, keep_err, len_err, user_err, seq_err, pkt_err_d;
  logic                  pkt_done, open_now, win_active;

  // Handshake: tready is tied high, so every cycle with tvalid=1 is an accepted
  // beat; tdata/tkeep/tlast/tuser are only looked at in such cycles.
  assign rx_axis_tready = 1'b1;
  assign beat           = rx_axis_tvalid;
  assign in_pkt_d       = beat ? !rx_axis_tlast : in_pkt_q;
  assign fsm_state      = state_q;

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      state_q  <= S_IDLE;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cfg_enable) state_d = in_pkt_d ? S_DROP : S_HEAD;
      S_DROP: if (beat && rx_axis_tlast) state_d = cfg_enable ? S_HEAD : S_IDLE;
      S_HEAD: begin
        if (!cfg_enable)                  state_d = S_IDLE;
        else if (beat && !rx_axis_tlast)  state_d = S_BODY;
      end
      S_BODY: if (beat && rx_axis_tlast) state_d = cfg_enable ? S_HEAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Once a packet head is checked, the packet is finished even if enable drops.
  assign is_head    = (state_q == S_HEAD);
  assign check_beat = beat && ((is_head && cfg_enable) || state_q == S_BODY);

  assign cur_size = is_head ? cfg_pkt_size : size_q;
  assign cur_seq  = is_head ? rx_axis_tdata[31:0] : seq_q;
  assign cur_b    = is_head ? 16'd0 : b_q;
  assign b_ext    = {1'b0, cur_b};
  assign n_beats  = ({1'b0, cur_size} + 17'(KEEP_WIDTH - 1)) >> KB;
  assign last_idx = n_beats - 17'd1;
  assign rem      = cur_size[KB-1:0];
  assign lane_exp = cur_seq + 32'(cur_b);

  always_comb begin
    lane_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (&rx_axis_tkeep[4*i +: 4] && rx_axis_tdata[32*i +: 32] != lane_exp) lane_err = 1'b1;
    end
  end

  always_comb begin
    exp_keep = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      exp_keep[k] = (b_ext < last_idx) || (rem == '0) || (KB'(k) < rem);
    end
  end

  assign keep_err  = (b_ext <= last_idx) && (rx_axis_tkeep != exp_keep);
  assign len_err   = rx_axis_tlast ? (b_ext != last_idx) : (b_ext >= last_idx);
  assign user_err  = rx_axis_tuser[0];
  assign seq_err   = is_head && is_recv_first_pkt && (rx_axis_tdata[31:0] != exp_seq_q);
  assign pkt_err_d = (!is_head && err_q) | lane_err | keep_err | len_err | user_err | seq_err;

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      seq_q     <= '0;
      exp_seq_q <= '0;
      size_q    <= '0;
      b_q       <= '0;
      err_q     <= 1'b0;
    end else if (check_beat) begin
      if (is_head) begin
        seq_q     <= rx_axis_tdata[31:0];
        exp_seq_q <= rx_axis_tdata[31:0] + 32'd1;
        size_q    <= cfg_pkt_size;
      end
      // Overlong packets park the index at N so the tail keeps flagging.
      b_q   <= (b_ext >= n_beats) ? cur_b : cur_b + 16'd1;
      err_q <= pkt_err_d;
    end
  end

  assign pkt_done   = check_beat && rx_axis_tlast;
  assign open_now   = check_beat && is_head && !is_recv_first_pkt;
  assign win_active = (perf_open_q || open_now) && !perf_cycle_full;

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      is_recv_first_pkt <= 1'b0;
      perf_open_q       <= 1'b0;
      recv_pkt_num      <= '0;
      err_pkt_num       <= '0;
      total_beat_count  <= '0;
      perf_beat_count   <= '0;
      perf_cycle_count  <= '0;
      perf_cycle_full   <= 1'b0;
    end else if (cfg_clear) begin
      is_recv_first_pkt <= 1'b0;
      perf_open_q       <= 1'b0;
      recv_pkt_num      <= '0;
      err_pkt_num       <= '0;
      total_beat_count  <= '0;
      perf_beat_count   <= '0;
      perf_cycle_count  <= '0;
      perf_cycle_full   <= 1'b0;
    end else begin
      if (pkt_done) begin
        recv_pkt_num <= recv_pkt_num + 1'b1;
        if (pkt_err_d) err_pkt_num <= err_pkt_num + 1'b1;
      end
      if (check_beat) total_beat_count <= total_beat_count + 1'b1;
      if (open_now) begin
        is_recv_first_pkt <= 1'b1;
        perf_open_q       <= 1'b1;
      end
      // The opening cycle counts, so beats never outrun cycles in the window.
      if (win_active) begin
        perf_cycle_count <= perf_cycle_count + 1'b1;
        if (perf_cycle_count == CYC_LAST) perf_cycle_full <= 1'b1;
        if (check_beat) perf_beat_count <= perf_beat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_udp_perf_rx_checker.sv
// Bench for udp_perf_rx_checker: scenario tasks plus a per-packet error-flag
// scoreboard; a CNT_WIDTH=8 instance shares the stimulus for saturation tests.
module tb_udp_perf_rx_checker;
  localparam int DW = 512;
  localparam int KW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_axis_tvalid = 1'b0;
  logic [DW-1:0] rx_axis_tdata = '0;
  logic [KW-1:0] rx_axis_tkeep = '0;
  logic          rx_axis_tlast = 1'b0;
  logic [0:0]    rx_axis_tuser = '0;
  logic          cfg_enable = 1'b0;
  logic [15:0]   cfg_pkt_size = 16'd256;
  logic          cfg_clear = 1'b0;

  logic        tready, first_pkt, pfull;
  logic [31:0] recv, errn, total, pbeat, pcyc;
  logic [1:0]  fsm_st;
  logic        tready8, first8, pfull8;
  logic [7:0]  recv8, err8, total8, pbeat8, pcyc8;
  logic [1:0]  fsm_st8;

  int checks = 0;
  int errors = 0;
  logic [0:0]  exp_q[$];
  logic        model_first = 1'b0;
  logic [31:0] model_exp_seq = '0;
  logic [31:0] prev_recv = '0;
  logic [31:0] prev_err = '0;

  always #5 clk = ~clk;

  udp_perf_rx_checker #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1), .CNT_WIDTH(32)) dut (
    .xdma_clk(clk), .xdma_reset(rst), .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tready(tready),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tuser(rx_axis_tuser), .cfg_enable(cfg_enable), .cfg_pkt_size(cfg_pkt_size),
    .cfg_clear(cfg_clear), .is_recv_first_pkt(first_pkt), .recv_pkt_num(recv), .err_pkt_num(errn),
    .total_beat_count(total), .perf_beat_count(pbeat), .perf_cycle_count(pcyc),
    .perf_cycle_full(pfull), .fsm_state(fsm_st));

  udp_perf_rx_checker #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1), .CNT_WIDTH(8)) dut8 (
    .xdma_clk(clk), .xdma_reset(rst), .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tready(tready8),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tuser(rx_axis_tuser), .cfg_enable(cfg_enable), .cfg_pkt_size(cfg_pkt_size),
    .cfg_clear(cfg_clear), .is_recv_first_pkt(first8), .recv_pkt_num(recv8), .err_pkt_num(err8),
    .total_beat_count(total8), .perf_beat_count(pbeat8), .perf_cycle_count(pcyc8),
    .perf_cycle_full(pfull8), .fsm_state(fsm_st8));

  // Scoreboard: each completed packet pops one expected error flag.
  always @(negedge clk) begin
    logic [0:0] e;
    if (rst) begin
      prev_recv = '0;
      prev_err  = '0;
    end else if (recv != prev_recv) begin
      if (recv == prev_recv + 32'd1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_pkt: recv=%0d with no expected packet", recv);
        end else begin
          e = exp_q.pop_front();
          if ((errn - prev_err) !== 32'(e)) begin
            errors++;
            $display("FAIL sb_pkt_err: pkt %0d err delta got %0d want %0d", recv, errn - prev_err, e);
          end
        end
      end
      prev_recv = recv;
      prev_err  = errn;
    end else if (errn != prev_err) begin
      checks++;
      errors++;
      $display("FAIL sb_err_without_pkt: err got %0d prev %0d", errn, prev_err);
      prev_err = errn;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
      rx_axis_tuser  = '0;
    end
  endtask

  task automatic drive_beat(input logic [31:0] val, input logic corrupt, input logic [KW-1:0] keep,
                            input logic last, input logic user, input logic en_off);
    @(negedge clk);
    rx_axis_tvalid = 1'b1;
    for (int i = 0; i < DW / 32; i++) rx_axis_tdata[32*i +: 32] = val;
    if (corrupt) rx_axis_tdata[31:0] = ~val;
    rx_axis_tkeep    = keep;
    rx_axis_tlast    = last;
    rx_axis_tuser[0] = user;
    if (en_off) cfg_enable = 1'b0;
  endtask

  // Sends beats first_b..nbeats-1 of a packet; checked packets get a modelled flag.
  task automatic send_pkt(input logic [31:0] seq, input int first_b, input int nbeats, input int corrupt_b,
                          input int user_b, input int en_off_b, input bit checked);
    int n_exp;
    int rem;
    logic bad;
    logic [KW-1:0] keep;
    n_exp = (int'(cfg_pkt_size) + KW - 1) / KW;
    rem   = int'(cfg_pkt_size) % KW;
    if (checked) begin
      bad = (nbeats != n_exp) || (corrupt_b >= 0) || (user_b >= 0) ||
            (model_first && seq != model_exp_seq);
      model_first   = 1'b1;
      model_exp_seq = seq + 32'd1;
      exp_q.push_back(bad);
    end
    for (int b = first_b; b < nbeats; b++) begin
      keep = '1;
      if (b == nbeats - 1 && rem != 0) keep = (KW'(1) << rem) - KW'(1);
      drive_beat(seq + 32'(b), b == corrupt_b, keep, b == nbeats - 1, b == user_b, b == en_off_b);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    rx_axis_tvalid = 1'b0;
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    model_first = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (tready !== 1'b1 || first_pkt !== 1'b0 || pfull !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: tready=%b first=%b full=%b want 1 0 0", tready, first_pkt, pfull);
    end
    checks++;
    if (recv !== 32'd0 || errn !== 32'd0 || total !== 32'd0 || pbeat !== 32'd0 || pcyc !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: recv=%0d err=%0d total=%0d pbeat=%0d pcyc=%0d want all 0",
               recv, errn, total, pbeat, pcyc);
    end
  endtask

  task automatic test_good_pkts();
    do_clear();
    cfg_pkt_size = 16'd256;
    for (int s = 0; s < 4; s++) send_pkt(32'(s), 0, 4, -1, -1, -1, 1'b1);
    idle(3);
    checks++;
    if (recv !== 32'd4 || errn !== 32'd0) begin
      errors++;
      $display("FAIL good_counts: recv=%0d err=%0d want 4 0", recv, errn);
    end
    checks++;
    if (total !== 32'd16 || pbeat !== 32'd16) begin
      errors++;
      $display("FAIL good_beats: total=%0d pbeat=%0d want 16 16", total, pbeat);
    end
    checks++;
    if (first_pkt !== 1'b1 || pfull !== 1'b0) begin
      errors++;
      $display("FAIL good_first: first=%b full=%b want 1 0", first_pkt, pfull);
    end
  endtask

  task automatic test_partial_keep();
    do_clear();
    cfg_pkt_size = 16'd100;
    for (int s = 0; s < 3; s++) send_pkt(32'(100 + s), 0, 2, (s == 1) ? 1 : -1, -1, -1, 1'b1);
    idle(3);
    checks++;
    if (recv !== 32'd3 || errn !== 32'd1 || total !== 32'd6) begin
      errors++;
      $display("FAIL keep_counts: recv=%0d err=%0d total=%0d want 3 1 6", recv, errn, total);
    end
  endtask

  task automatic test_seq_gap();
    logic [31:0] seqs [4];
    seqs[0] = 32'd10; seqs[1] = 32'd11; seqs[2] = 32'd13; seqs[3] = 32'd14;
    do_clear();
    cfg_pkt_size = 16'd64;
    for (int s = 0; s < 4; s++) send_pkt(seqs[s], 0, 1, -1, -1, -1, 1'b1);
    idle(3);
    checks++;
    if (recv !== 32'd4 || errn !== 32'd1 || total !== 32'd4) begin
      errors++;
      $display("FAIL seq_counts: recv=%0d err=%0d total=%0d want 4 1 4", recv, errn, total);
    end
  endtask

  task automatic test_length_user();
    do_clear();
    cfg_pkt_size = 16'd256;
    send_pkt(32'd0, 0, 2, -1, -1, -1, 1'b1);
    send_pkt(32'd1, 0, 6, -1, -1, -1, 1'b1);
    send_pkt(32'd2, 0, 4, -1, 2, -1, 1'b1);
    idle(3);
    checks++;
    if (recv !== 32'd3 || errn !== 32'd3 || total !== 32'd12) begin
      errors++;
      $display("FAIL len_counts: recv=%0d err=%0d total=%0d want 3 3 12", recv, errn, total);
    end
  endtask

  task automatic test_enable_rise_mid_pkt();
    do_clear();
    cfg_enable = 1'b0;
    idle(2);
    drive_beat(32'd50, 1'b0, '1, 1'b0, 1'b0, 1'b0);
    drive_beat(32'd51, 1'b0, '1, 1'b0, 1'b0, 1'b0);
    idle(1);
    cfg_enable = 1'b1;
    send_pkt(32'd50, 2, 4, -1, -1, -1, 1'b0);
    send_pkt(32'd60, 0, 4, -1, -1, -1, 1'b1);
    idle(3);
    checks++;
    if (recv !== 32'd1 || errn !== 32'd0 || total !== 32'd4 || first_pkt !== 1'b1) begin
      errors++;
      $display("FAIL drop_counts: recv=%0d err=%0d total=%0d first=%b want 1 0 4 1",
               recv, errn, total, first_pkt);
    end
  endtask

  task automatic test_enable_fall();
    logic [31:0] cyc0;
    do_clear();
    send_pkt(32'd70, 0, 4, -1, -1, 2, 1'b1);
    send_pkt(32'd71, 0, 4, -1, -1, -1, 1'b0);
    idle(3);
    checks++;
    if (recv !== 32'd1 || errn !== 32'd0 || total !== 32'd4) begin
      errors++;
      $display("FAIL fall_counts: recv=%0d err=%0d total=%0d want 1 0 4", recv, errn, total);
    end
    cyc0 = pcyc;
    idle(5);
    checks++;
    if (pcyc !== cyc0 + 32'd5) begin
      errors++;
      $display("FAIL fall_perf_cycles: pcyc=%0d want %0d", pcyc, cyc0 + 32'd5);
    end
    cfg_enable = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid_pkt();
    drive_beat(32'd500, 1'b0, '1, 1'b0, 1'b0, 1'b0);
    drive_beat(32'd501, 1'b0, '1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    rx_axis_tvalid = 1'b0;
    idle(2);
    checks++;
    if (recv !== 32'd0 || errn !== 32'd0 || total !== 32'd0 || pbeat !== 32'd0 || pcyc !== 32'd0 ||
        first_pkt !== 1'b0 || pfull !== 1'b0 || tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: recv=%0d err=%0d total=%0d pbeat=%0d pcyc=%0d first=%b tready=%b",
               recv, errn, total, pbeat, pcyc, first_pkt, tready);
    end
    rst = 1'b0;
    model_first = 1'b0;
    idle(2);
    send_pkt(32'd900, 0, 4, -1, -1, -1, 1'b1);
    idle(3);
    checks++;
    if (recv !== 32'd1 || errn !== 32'd0 || total !== 32'd4) begin
      errors++;
      $display("FAIL rst_mid_after: recv=%0d err=%0d total=%0d want 1 0 4", recv, errn, total);
    end
  endtask

  task automatic test_back_to_back_perf();
    do_clear();
    cfg_pkt_size = 16'd256;
    for (int s = 0; s < 70; s++) send_pkt(32'(1000 + s), 0, 4, -1, -1, -1, 1'b1);
    idle(3);
    checks++;
    if (recv !== 32'd70 || errn !== 32'd0 || total !== 32'd280) begin
      errors++;
      $display("FAIL b2b_counts: recv=%0d err=%0d total=%0d want 70 0 280", recv, errn, total);
    end
    checks++;
    if (pfull8 !== 1'b1 || pcyc8 !== 8'd255 || pbeat8 !== 8'd255) begin
      errors++;
      $display("FAIL perf_sat: full=%b pcyc=%0d pbeat=%0d want 1 255 255", pfull8, pcyc8, pbeat8);
    end
    checks++;
    if (total8 !== 8'd24 || recv8 !== 8'd70) begin
      errors++;
      $display("FAIL cnt8_wrap: total=%0d recv=%0d want 24 70", total8, recv8);
    end
    do_clear();
    checks++;
    if (recv8 !== 8'd0 || err8 !== 8'd0 || total8 !== 8'd0 || pbeat8 !== 8'd0 || pcyc8 !== 8'd0 ||
        pfull8 !== 1'b0 || first8 !== 1'b0) begin
      errors++;
      $display("FAIL clear8: recv=%0d err=%0d total=%0d pbeat=%0d pcyc=%0d full=%b first=%b",
               recv8, err8, total8, pbeat8, pcyc8, pfull8, first8);
    end
    send_pkt(32'd5000, 0, 4, -1, -1, -1, 1'b1);
    idle(2);
    checks++;
    if (first8 !== 1'b1 || pbeat8 !== 8'd4 || pcyc8 !== 8'd5 || pfull8 !== 1'b0) begin
      errors++;
      $display("FAIL reopen8: first=%b pbeat=%0d pcyc=%0d full=%b want 1 4 5 0",
               first8, pbeat8, pcyc8, pfull8);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    cfg_enable = 1'b1;
    idle(2);
    test_good_pkts();
    test_partial_keep();
    test_seq_gap();
    test_length_user();
    test_enable_rise_mid_pkt();
    test_enable_fall();
    test_reset_mid_pkt();
    test_back_to_back_perf();
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected packets never completed, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
